// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide definitions.
//   CPU_ADDR_SIZE / CPU_INSTR_SIZE : default instruction address and word widths
//   fetch_entry_t                  : {ip, instr} pair as delivered to the decoder
//   countWidth()                   : width of a 0..depth counter
package cpu_pkg;

  localparam int CPU_ADDR_SIZE  = 16;
  localparam int CPU_INSTR_SIZE = 32;

  typedef struct packed {
    logic [CPU_ADDR_SIZE-1:0]  ip;
    logic [CPU_INSTR_SIZE-1:0] instr;
  } fetch_entry_t;

  // A counter that must hold the value "depth" itself needs one extra bit.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous circular FIFO holding prefetched instructions.
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write wdata_i at the tail
//   wdata_i   : entry to write
//   pop_i     : drop the head entry
//   flush_i   : empty the FIFO (wins over push/pop)
//   count_o   : number of stored entries, 0..DEPTH
//   rdata_o   : head entry (valid when count_o != 0)
// DEPTH must be a power of two; the pointers carry one extra bit so that
// full and empty remain distinguishable after wrap-around.
module fetch_fifo #(
  parameter int DATA_SIZE = 48,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [DATA_SIZE-1:0]   wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DATA_SIZE-1:0]   rdata_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]          wrPtr_q, wrPtr_d;
  logic [AW:0]          rdPtr_q, rdPtr_d;
  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  // Pointer update: flush returns both pointers to the origin, otherwise
  // push and pop advance their own pointer independently.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + PTR_ONE;
      if (pop_i)  rdPtr_d = rdPtr_q + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

  assign count_o = wrPtr_q - rdPtr_q;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch front end with a request/response memory port.
//   clk, rst       : clock, asynchronous active-high reset
//   mem_req_*      : fetch request (valid/ready) and address
//   mem_resp_*     : in-order responses, no backpressure
//   redirect(_addr): taken jump; flushes the prefetch FIFO, restarts fetch
//   out_*          : {ip, instr} towards the decoder (valid/ready)
//   occupancy      : prefetch FIFO entry count
// Requests are only issued while in-flight requests plus stored entries stay
// below DEPTH, so every response always finds room in the FIFO.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                   ADDR_SIZE  = CPU_ADDR_SIZE,
  parameter int                   INSTR_SIZE = CPU_INSTR_SIZE,
  parameter int                   DEPTH      = 4,
  parameter logic [ADDR_SIZE-1:0] INCR       = ADDR_SIZE'(1),
  parameter logic [ADDR_SIZE-1:0] RESET_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_SIZE-1:0]          mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [INSTR_SIZE-1:0]         mem_resp_data,
  input  logic                          redirect,
  input  logic [ADDR_SIZE-1:0]          redirect_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTR_SIZE-1:0]         out_instr,
  output logic [ADDR_SIZE-1:0]          out_ip,
  output logic [countWidth(DEPTH)-1:0]  occupancy
);

  localparam int CW = countWidth(DEPTH);
  localparam int EW = ADDR_SIZE + INSTR_SIZE;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(DEPTH);

  logic [ADDR_SIZE-1:0] fetchIp_q, fetchIp_d;
  logic [ADDR_SIZE-1:0] respIp_q, respIp_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        discard_q, discard_d;

  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic [CW:0]   creditUsed;
  logic          reqFire;
  logic          respKeep;
  logic          popFire;

  // Credits are computed from registered counts only, one bit wider so the
  // sum cannot overflow.
  assign creditUsed    = {1'b0, outstanding_q} + {1'b0, count};
  assign mem_req_valid = !rst && !redirect && (creditUsed < DEPTH_LIM);
  assign mem_req_addr  = fetchIp_q;
  assign reqFire       = mem_req_valid && mem_req_ready;

  assign respKeep  = mem_resp_valid && !redirect && (discard_q == '0);
  assign out_valid = (count != '0) && !redirect;
  assign popFire   = out_valid && out_ready;

  // Next-state for fetch/response pointers and the two request counters.
  // A redirect turns every request still in flight after this edge into a
  // stale one; the response arriving in the redirect cycle is dropped.
  always_comb begin
    fetchIp_d     = fetchIp_q;
    respIp_d      = respIp_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q;
    if (reqFire)        outstanding_d = outstanding_d + CNT_ONE;
    if (mem_resp_valid) outstanding_d = outstanding_d - CNT_ONE;
    if (redirect) begin
      fetchIp_d = redirect_addr;
      respIp_d  = redirect_addr;
      discard_d = mem_resp_valid ? (outstanding_q - CNT_ONE) : outstanding_q;
    end else begin
      if (reqFire) fetchIp_d = fetchIp_q + INCR;
      if (mem_resp_valid) begin
        if (discard_q != '0) discard_d = discard_q - CNT_ONE;
        else                 respIp_d  = respIp_q + INCR;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchIp_q     <= RESET_ADDR;
      respIp_q      <= RESET_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetchIp_q     <= fetchIp_d;
      respIp_q      <= respIp_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DATA_SIZE (EW),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (respKeep),
    .wdata_i ({respIp_q, mem_resp_data}),
    .pop_i   (popFire),
    .flush_i (redirect),
    .count_o (count),
    .rdata_o (head)
  );

  assign out_ip    = head[EW-1 -: ADDR_SIZE];
  assign out_instr = head[INSTR_SIZE-1:0];
  assign occupancy = count;

  // A response with nothing in flight means the memory broke the protocol.
  respHasRequest: assert property (@(posedge clk) disable iff (rst)
    mem_resp_valid |-> (outstanding_q != '0));

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Parametrised instruction-fetch front end for the CPU driver. It owns the instruction pointer and replaces the combinational `rom[ip]` lookup with a request/response memory port, so instruction memory may have variable latency. It prefetches into a FIFO of depth DEPTH and delivers `{ip, instr}` pairs to the decoder over a valid/ready handshake. A jump redirects fetch, flushes the FIFO and drops any responses still in flight.

## Interface
- ADDR_SIZE, 16, instruction address width
- INSTR_SIZE, 32, instruction word width
- DEPTH, 4, prefetch FIFO depth and maximum in-flight requests (power of two, ≥2)
- INCR, 1, address step per instruction
- RESET_ADDR, 0, IP after reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_SIZE  fetch address
- mem_resp_valid  in  1  response valid; responses arrive in request order, no backpressure
- mem_resp_data  in  INSTR_SIZE  instruction word
- redirect  in  1  jump taken this cycle
- redirect_addr  in  ADDR_SIZE  jump target
- out_valid  out  1  instruction available
- out_ready  in  1  decoder consumes instruction
- out_instr  out  INSTR_SIZE  instruction at FIFO head
- out_ip  out  ADDR_SIZE  address of out_instr
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count

## Operation
- State:
  - fetch_ip: next request address
  - resp_ip: address of the next kept response
  - outstanding: requests accepted but not yet answered, 0..DEPTH
  - discard: stale responses still to drop, 0..DEPTH
  - FIFO of `{ip, instr}` entries
- Issue:
  - mem_req_valid = !rst && !redirect && (outstanding + count < DEPTH), using registered values only.
  - A pop in the same cycle does not free a credit until the next cycle.
  - mem_req_addr = fetch_ip.
  - On handshake: fetch_ip += INCR, modulo 2^ADDR_SIZE (wraps silently); outstanding += 1.
- Response:
  - outstanding −= 1.
  - If discard > 0: drop the word; discard −= 1.
  - Else: push `{resp_ip, mem_resp_data}`; resp_ip += INCR, also wrapping.
  - The credit rule guarantees the FIFO never overflows. A response arriving with outstanding = 0 is a protocol error; assert it in simulation.
- Output:
  - out_valid = (count > 0) && !redirect.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged.
- Redirect, which has priority over everything else that cycle:
  - FIFO flushed to count 0.
  - fetch_ip ← redirect_addr; resp_ip ← redirect_addr.
  - A response arriving this cycle is dropped.
  - discard ← outstanding − (mem_resp_valid ? 1 : 0), i.e. every request still in flight after this cycle. No request is issued this cycle.
  - outstanding is updated normally for the response; discard then tracks it.

## Timing
- Reset values: fetch_ip = resp_ip = RESET_ADDR; outstanding = discard = 0; FIFO empty; out_valid = 0; occupancy = 0.
  - mem_req_valid = 0 while rst is high.
  - mem_req_valid = 1 in the first cycle after release, with mem_req_addr = RESET_ADDR.
- Reset asserted mid-operation clears all state asynchronously. Responses to requests issued before reset are not tracked; the memory must be reset alongside.
- Latency: a response accepted at edge N is visible at the FIFO head (out_valid = 1) after edge N, i.e. in cycle N+1. No bypass from mem_resp_data to out_instr.
- Throughput: one instruction per cycle sustained with single-cycle memory and out_ready held high.
- Redirect at edge N:
  - First new request in cycle N+1.
  - First target instruction no earlier than cycle N+3 with single-cycle memory.
- out_instr/out_ip are stable while out_valid && !out_ready (no redirect).

## Structure
- Package cpu_pkg: default ADDR_SIZE/INSTR_SIZE localparams and a fetch_entry_t struct for the default widths, so the decoder can import it.
- Sub-module fetch_fifo:
  - Synchronous circular FIFO, parameters DATA_SIZE and DEPTH.
  - Ports: push, pop, flush, count, head data.
  - Wrap-around via a one-bit-extended pointer.
- Counter and credit logic stay in instr_fetch.

## Test plan
- Reset release, memory with 1-cycle latency, out_ready = 1 → requests at 0,1,2,…; out_ip 0,1,2,… on consecutive cycles from cycle 3; no gaps.
- out_ready = 0, DEPTH = 4 → exactly 4 requests issued; occupancy reaches 4; mem_req_valid stays 0 until a pop, then resumes the cycle after.
- Memory latency 3, redirect to 0x0040 with 2 requests in flight → both stale responses dropped; the next out_instr has out_ip = 0x0040; no instruction from the old stream appears.
- Redirect in the same cycle as a response and a pop → response dropped, FIFO empty next cycle, discard = outstanding − 1, fetch resumes at the target.
- ADDR_SIZE = 4, start via redirect to 0xE → out_ip sequence E, F, 0, 1 (wrap).
- rst asserted while occupancy = 3 and outstanding = 1 → out_valid and mem_req_valid fall immediately (asynchronously); after release, fetch restarts at RESET_ADDR with occupancy 0.
